// File: rtl/fpu_pkg.sv
// Shared types and helpers for the sequential FPU arithmetic unit.
// Holds the op encoding, FSM states, per-class latency lookup and counter sizing.
// Latency parameters live in the top, so the helpers take them as arguments.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_IDLE = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_MAX  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // Class latency: MUL has its own, the bitwise ops share one, and
  // ADD/SUB/MAX share the adder latency.
  function automatic int lat_of(op_e op, int lat_add, int lat_mul, int lat_logic);
    case (op)
      OP_MUL:                return lat_mul;
      OP_AND, OP_OR, OP_XOR: return lat_logic;
      default:               return lat_add;
    endcase
  endfunction

  // Counter width: wide enough for the largest (LAT - 1) plus one spare bit.
  function automatic int cnt_w(int lat_add, int lat_mul, int lat_logic);
    int m;
    m = lat_add;
    if (lat_mul > m)   m = lat_mul;
    if (lat_logic > m) m = lat_logic;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fpu_seq_alu.sv
// Combinational datapath of the sequential FPU unit: (op, a, b) -> (result, ovf, zero).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
// Ports: op/a/b operation and operands; result, ovf (signed add/sub overflow or
// nonzero MUL high half), zero (result == 0).
module fpu_seq_alu
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf,
  output logic                  zero
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0]   sum;
  logic [DATA_WIDTH-1:0]   diff;
  logic [2*DATA_WIDTH-1:0] prod;

  assign sum  = a + b;
  assign diff = a - b;
  assign prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        // Same-sign operands producing a different-sign sum.
        ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = diff;
        // Opposite-sign operands where the difference takes b's sign.
        ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_MUL: begin
        result = prod[DATA_WIDTH-1:0];
        ovf    = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MAX:  result = ($signed(a) > $signed(b)) ? a : b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/fpu_seq_unit.sv
// Multi-cycle arithmetic unit: latches one op, waits its class latency, holds the result.
// Latency: exactly LAT(op) cycles from accept edge to out_valid; back-to-back every LAT+1.
// Backpressure: result held in HOLD until out_ready; in_ready low while RUN or blocked HOLD.
// Ports: clock/reset_n, flush (sync abort), in_valid/in_ready/op/a/b request side,
// out_valid/out_ready/result/ovf/zero response side, busy (state != IDLE).
module fpu_seq_unit
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LAT_ADD    = 31,
  parameter int LAT_MUL    = 31,
  parameter int LAT_LOGIC  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf,
  output logic                  zero,
  output logic                  busy
);

  localparam int CNT_W = cnt_w(LAT_ADD, LAT_MUL, LAT_LOGIC);

  state_e                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  op_e                   op_q, op_n;
  logic [DATA_WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [DATA_WIDTH-1:0] result_n;
  logic                  ovf_n, zero_n;
  logic                  accept;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_ovf, alu_zero;

  fpu_seq_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .ovf    (alu_ovf),
    .zero   (alu_zero)
  );

  assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready && (op != OP_IDLE) && !flush;
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= OP_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      a_q    <= a_n;
      b_q    <= b_n;
      result <= result_n;
      ovf    <= ovf_n;
      zero   <= zero_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    result_n = result;
    ovf_n    = ovf;
    zero_n   = zero;

    if (flush) begin
      // Abort everything but keep the last result/flags on the bus.
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_n    = op_e'(op);
            a_n     = a;
            b_n     = b;
            cnt_n   = CNT_W'(lat_of(op_e'(op), LAT_ADD, LAT_MUL, LAT_LOGIC) - 1);
            state_n = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else begin
            result_n = alu_result;
            ovf_n    = alu_ovf;
            zero_n   = alu_zero;
            state_n  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // The drain edge can also accept the next op (back-to-back).
          if (out_ready) begin
            if (accept) begin
              op_n    = op_e'(op);
              a_n     = a;
              b_n     = b;
              cnt_n   = CNT_W'(lat_of(op_e'(op), LAT_ADD, LAT_MUL, LAT_LOGIC) - 1);
              state_n = ST_RUN;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq_unit.sv
// Scoreboard bench for fpu_seq_unit with directed vectors.
// Stimulus pushes expected result/flags/arrival cycle; a negedge monitor checks each new result.
module tb_fpu_seq_unit;
  import fpu_pkg::*;

  localparam int W  = 32;
  localparam int LA = 31;
  localparam int LM = 31;
  localparam int LL = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, ovf, zero, busy;
  logic [W-1:0] result;

  fpu_seq_unit #(
    .DATA_WIDTH(W), .LAT_ADD(LA), .LAT_MUL(LM), .LAT_LOGIC(LL)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         zero;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_v = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every rising out_valid must match the oldest outstanding op.
  always @(negedge clock) begin
    exp_t e;
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got result %0h expected no result", result);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("ovf", ovf, e.ovf);
        check("zero", zero, e.zero);
        check("latency_cycle", cyc, e.cyc);
      end
    end
    prev_v <= out_valid;
  end

  // Called at a negedge; returns at the negedge after the accept edge, with
  // operands scrambled so late changes cannot leak into the result.
  task automatic issue(op_e o, logic [W-1:0] va, logic [W-1:0] vb,
                       logic [W-1:0] r, logic v, logic z, int lat);
    exp_t e;
    int t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("issue_in_ready", in_ready, 1);
    in_valid = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
    e.res  = r;
    e.ovf  = v;
    e.zero = z;
    e.cyc  = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
    op       = 3'b000;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
  endtask

  task automatic wait_valid(string name);
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clock);
      t++;
    end
    check(name, out_valid, 1);
  endtask

  task automatic run(op_e o, logic [W-1:0] va, logic [W-1:0] vb,
                     logic [W-1:0] r, logic v, logic z, int lat);
    issue(o, va, vb, r, v, z, lat);
    wait_valid("wait_result");
    @(negedge clock);
    check("drained", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1);
  end

  initial begin
    logic bad;

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);

    // op == IDLE with in_valid must be ignored.
    bad = 1'b0;
    in_valid = 1'b1; op = 3'b000; a = 5; b = 7;
    repeat (10) begin
      @(negedge clock);
      if (busy || out_valid) bad = 1'b1;
    end
    in_valid = 1'b0;
    check("idle_op_ignored", bad, 0);

    run(OP_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, LA);
    run(OP_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1, 1'b0, LA);
    run(OP_SUB, 32'd3,          32'd3,          32'd0,          1'b0, 1'b1, LA);
    run(OP_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 1'b0, LA);
    run(OP_MUL, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 1'b1, LM);
    run(OP_MUL, 32'd3,          32'd4,          32'd12,         1'b0, 1'b0, LM);
    run(OP_MAX, 32'hFFFF_FFFF,  32'd2,          32'd2,          1'b0, 1'b0, LA);
    run(OP_MAX, 32'd5,          32'hFFFF_FFFD,  32'd5,          1'b0, 1'b0, LA);
    run(OP_OR,  32'h0000_00A0,  32'h0000_0005,  32'h0000_00A5,  1'b0, 1'b0, LL);

    // Back-pressure: XOR result must stay put while out_ready is low.
    out_ready = 1'b0;
    issue(OP_XOR, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1'b0, LL);
    wait_valid("wait_xor");
    bad = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (!out_valid || result !== 32'h0000_000F) bad = 1'b1;
    end
    check("xor_held_stable", bad, 0);

    // Drain edge accepts the pending AND.
    out_ready = 1'b1;
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, LL);
    check("b2b_gap_out_valid", out_valid, 0);
    check("b2b_busy", busy, 1);
    wait_valid("wait_and");
    @(negedge clock);

    // Flush during RUN with a competing request.
    issue(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, LA);
    repeat (5) @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0; op = 3'b000;
    void'(sb.pop_back());
    check("flush_busy", busy, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_keeps_result", result, 32'h0000_00F0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid || busy) bad = 1'b1;
    end
    check("flush_no_result", bad, 0);

    // Flush beats an accept in IDLE.
    flush = 1'b1; in_valid = 1'b1; op = OP_MUL;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0; op = 3'b000;
    check("flush_beats_accept", busy, 0);

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    issue(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, LM);
    wait_valid("wait_mul_hold");
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_result", result, 0);
    check("async_reset_busy", busy, 0);
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
